// File: rtl/rob_pkg.sv
// Shared ROB/CDB definitions: entry count, tag and value widths, and the
// common-data-bus slot record consumed by the ROB and reservation stations.
package rob_pkg;

  localparam int ROB_ENTRIES = 32;
  localparam int ROB_IDX_W   = $clog2(ROB_ENTRIES);
  localparam int VAL_W       = 64;

  typedef struct packed {
    logic                 valid;
    logic [VAL_W-1:0]     value;
    logic [ROB_IDX_W-1:0] rob_idx;
  } cdb_slot_t;

endpackage

// File: rtl/rr_picker.sv
// Circular priority picker: finds the first set request bit at or after ptr,
// wrapping modulo NUM_FU.
module rr_picker #(
  parameter int NUM_FU = 4,
  parameter int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic [NUM_FU-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic              found,
  output logic [PTR_W-1:0]  idx
);

  // Scan from the far end so the nearest hit to ptr is the last one written.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_FU-1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_FU;
      if (req[j]) begin
        found = 1'b1;
        idx   = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Grants up to two of NUM_FU completing FUs per cycle (round-robin) onto the
// two registered CDB slots feeding the ROB and reservation stations.
module cdb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int VAL_W     = rob_pkg::VAL_W,
  parameter int ROB_IDX_W = rob_pkg::ROB_IDX_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        squash,
  input  logic [NUM_FU-1:0]           fu_valid,
  input  logic [NUM_FU*VAL_W-1:0]     fu_value,
  input  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx,
  output logic [NUM_FU-1:0]           fu_ready,
  output logic                        cdb1_valid,
  output logic [VAL_W-1:0]            cdb1_value,
  output logic [ROB_IDX_W-1:0]        cdb1_rob_idx,
  output logic                        cdb2_valid,
  output logic [VAL_W-1:0]            cdb2_value,
  output logic [ROB_IDX_W-1:0]        cdb2_rob_idx
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic                 valid;
    logic [VAL_W-1:0]     value;
    logic [ROB_IDX_W-1:0] rob_idx;
  } slot_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_FU-1)) ? '0 : p + 1'b1;
  endfunction

  logic [NUM_FU-1:0][VAL_W-1:0]     val_arr;
  logic [NUM_FU-1:0][ROB_IDX_W-1:0] tag_arr;
  logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
  slot_t                            cdb1_q, cdb1_d, cdb2_q, cdb2_d;
  logic                             g1_found, g2_found;
  logic [PTR_W-1:0]                 g1, g2;
  logic [NUM_FU-1:0]                req2;

  assign val_arr = fu_value;
  assign tag_arr = fu_rob_idx;

  rr_picker #(.NUM_FU(NUM_FU), .PTR_W(PTR_W)) u_pick1 (
    .req   (fu_valid),
    .ptr   (rr_ptr_q),
    .found (g1_found),
    .idx   (g1)
  );

  // Second pick excludes g1 and continues the circular search just past it.
  assign req2 = fu_valid & ~(NUM_FU'(1) << g1);

  rr_picker #(.NUM_FU(NUM_FU), .PTR_W(PTR_W)) u_pick2 (
    .req   (req2),
    .ptr   (ptr_inc(g1)),
    .found (g2_found),
    .idx   (g2)
  );

  for (genvar i = 0; i < NUM_FU; i++) begin : g_ready
    assign fu_ready[i] = reset & ~squash &
                         ((g1_found & (g1 == PTR_W'(i))) | (g2_found & (g2 == PTR_W'(i))));
  end

  always_comb begin
    cdb1_d   = '0;
    cdb2_d   = '0;
    rr_ptr_d = rr_ptr_q;
    if (!squash) begin
      if (g1_found) begin
        cdb1_d   = '{valid: 1'b1, value: val_arr[g1], rob_idx: tag_arr[g1]};
        rr_ptr_d = ptr_inc(g1);
      end
      // g2 can only exist when g1 does, so slot 2 never fires alone.
      if (g2_found) begin
        cdb2_d   = '{valid: 1'b1, value: val_arr[g2], rob_idx: tag_arr[g2]};
        rr_ptr_d = ptr_inc(g2);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      cdb1_q   <= '0;
      cdb2_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb1_q   <= cdb1_d;
      cdb2_q   <= cdb2_d;
    end
  end

  assign cdb1_valid   = cdb1_q.valid;
  assign cdb1_value   = cdb1_q.value;
  assign cdb1_rob_idx = cdb1_q.rob_idx;
  assign cdb2_valid   = cdb2_q.valid;
  assign cdb2_value   = cdb2_q.value;
  assign cdb2_rob_idx = cdb2_q.rob_idx;

endmodule
